// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM encoding, header layout,
// and the state-to-status decode used for the registered status outputs.
package cpu_pkg;

    localparam int HDR_LEN_BITS   = 5;
    localparam int HDR_RSVD_BITS  = 3;
    localparam int MAX_WORDS      = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
        logic cpu_rst;
    } status_t;

    // The core stays in reset while loading and after a failed load.
    function automatic status_t state_status(input state_t s);
        status_t st;
        st = '0;
        case (s)
            HDR, DATA, CHK: begin
                st.busy    = 1'b1;
                st.cpu_rst = 1'b1;
            end
            DONE: st.done = 1'b1;
            ERR: begin
                st.err     = 1'b1;
                st.cpu_rst = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

    function automatic logic state_accepts(input state_t s);
        return (s == HDR) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, program-memory write port and status of the loader.
// master = loader side, slave = host / memory side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  cpu_rst;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH:0]   word_count;

    modport master (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err, word_count
    );

    modport slave (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err, word_count
    );
endinterface

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembly; word_ready flags the byte that
// completes a word, with the full word presented on word_next that cycle.
module word_assembler
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             accept,
    input  logic [7:0]       byte_in,
    output logic             word_ready,
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-9:0] hold_r;
    logic [1:0]       idx_r;

    assign word_next  = {byte_in, hold_r};
    assign word_ready = accept && (idx_r == 2'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in from the top so the first byte ends up lowest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= '0;
            idx_r  <= 2'd0;
        end else if (clr) begin
            hold_r <= '0;
            idx_r  <= 2'd0;
        end else if (accept) begin
            hold_r <= word_next[WIDTH-1:8];
            idx_r  <= idx_r + 2'd1;
        end else begin
            hold_r <= hold_r;
            idx_r  <= idx_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Session FSM, word counter and XOR checksum for loading a program image
// from a byte stream into program memory while holding the CPU in reset.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    program_loader_if.master  bus
);

    localparam int CW = ADDR_WIDTH + 1;

    state_t                state_r;
    state_t                state_nx_s;
    status_t               status_r;
    logic                  accept_s;
    logic                  data_accept_s;
    logic                  hdr_bad_s;
    logic                  last_word_s;
    logic                  word_ready_s;
    logic [WIDTH-1:0]      word_next_s;
    logic [7:0]            chk_r;
    logic [CW-1:0]         n_words_r;
    logic [CW-1:0]         word_count_r;
    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [WIDTH-1:0]      wr_data_r;

    // A start pulse wins over any byte offered in the same cycle.
    assign accept_s      = bus.byte_valid && state_accepts(state_r) && !bus.start;
    assign data_accept_s = accept_s && (state_r == DATA);
    assign hdr_bad_s     = |bus.byte_in[7:HDR_LEN_BITS];
    assign last_word_s   = word_ready_s && ((word_count_r + CW'(1)) == n_words_r);

    word_assembler #(
        .WIDTH (WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.start),
        .accept     (data_accept_s),
        .byte_in    (bus.byte_in),
        .word_ready (word_ready_s),
        .word_next  (word_next_s)
    );

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        if (bus.start) begin
            state_nx_s = HDR;
        end else begin
            case (state_r)
                HDR: begin
                    if (accept_s) begin
                        if (hdr_bad_s) begin
                            state_nx_s = ERR;
                        end else begin
                            state_nx_s = DATA;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                DATA: begin
                    if (last_word_s) begin
                        state_nx_s = CHK;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                CHK: begin
                    if (accept_s) begin
                        if (bus.byte_in == chk_r) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = ERR;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                IDLE, DONE, ERR: state_nx_s = state_r;
                default:         state_nx_s = IDLE;
            endcase
        end
    end

    // State register with status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            status_r <= '0;
        end else begin
            state_r  <= state_nx_s;
            status_r <= state_status(state_nx_s);
        end
    end

    // Checksum, word counter and program-memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_r        <= 8'h00;
            n_words_r    <= '0;
            word_count_r <= '0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
        end else begin
            wr_en_r <= word_ready_s;
            if (bus.start) begin
                chk_r        <= 8'h00;
                n_words_r    <= '0;
                word_count_r <= '0;
            end else begin
                if (accept_s && (state_r == HDR)) begin
                    chk_r     <= bus.byte_in;
                    n_words_r <= CW'(bus.byte_in[HDR_LEN_BITS-1:0]) + CW'(1);
                end else if (data_accept_s) begin
                    chk_r <= chk_r ^ bus.byte_in;
                end
                if (word_ready_s) begin
                    word_count_r <= word_count_r + CW'(1);
                    wr_addr_r    <= word_count_r[ADDR_WIDTH-1:0];
                    wr_data_r    <= word_next_s;
                end
            end
        end
    end

    assign bus.byte_ready = state_accepts(state_r);
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.word_count = word_count_r;
    assign bus.busy       = status_r.busy;
    assign bus.done       = status_r.done;
    assign bus.err        = status_r.err;
    assign bus.cpu_rst    = status_r.cpu_rst;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written corner
// sequences and randomized sessions scored against a stream-level model.
module tb_program_loader;

    localparam int AW = 5;
    localparam int W  = 32;

    typedef logic [AW+W-1:0] wr_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  chk;
        bit          done;
        bit          err;
        int          cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW), .WIDTH(W)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    bit         exp_done;
    bit         exp_err;
    int         exp_cnt;
    vec_t       vecs[5];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got_q.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        bit rdy;
        ok = 1'b0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rdy = bus.byte_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%0h", b);
        end
    endtask

    task automatic send_stream();
        foreach (tx_q[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(tx_q[i]);
            if (i == 0) check("cpu_rst_in_session", bus.cpu_rst, 1'b1);
        end
    endtask

    // Bytes offered after the session ends must be ignored.
    task automatic junk_offer();
        bus.byte_valid = 1'b1;
        repeat (3) begin
            bus.byte_in = 8'($urandom);
            tick();
        end
        bus.byte_valid = 1'b0;
        tick();
    endtask

    task automatic check_end(input string tag);
        check({tag, "_done"}, bus.done, exp_done);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_cpu_rst"}, bus.cpu_rst, exp_err);
        check({tag, "_byte_ready"}, bus.byte_ready, 1'b0);
        check({tag, "_word_count"}, bus.word_count, exp_cnt);
        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_write"}, got_q[i], exp_q[i]);
    endtask

    // Reference: interpret the whole byte stream from the protocol rules.
    task automatic model();
        logic [7:0]  h;
        logic [7:0]  x;
        logic [31:0] w;
        int          n;
        exp_q.delete();
        h = tx_q[0];
        if (h[7:5] != 3'd0) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_cnt  = 0;
        end else begin
            n = int'(h[4:0]) + 1;
            x = 8'h00;
            for (int j = 0; j <= 4 * n; j++) x = x ^ tx_q[j];
            for (int i = 0; i < n; i++) begin
                w = {tx_q[4*i+4], tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1]};
                exp_q.push_back({AW'(i), w});
            end
            exp_cnt  = n;
            exp_done = (tx_q[4*n+1] == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic build_random(input int n, input bit good_hdr, input bit good_chk);
        logic [7:0] x;
        logic [7:0] b;
        tx_q.delete();
        if (!good_hdr) begin
            tx_q.push_back({3'($urandom_range(1, 7)), 5'($urandom)});
        end else begin
            x = 8'(n - 1);
            tx_q.push_back(x);
            repeat (4 * n) begin
                b = 8'($urandom);
                tx_q.push_back(b);
                x = x ^ b;
            end
            if (good_chk) tx_q.push_back(x);
            else tx_q.push_back(x ^ 8'($urandom_range(1, 255)));
        end
    endtask

    initial begin
        logic [31:0] wv;
        int          n;

        vecs[0] = '{8'h01, 32'h000070FF, 32'h00000001, 8'h8F, 1'b1, 1'b0, 2};
        vecs[1] = '{8'h01, 32'h000070FF, 32'h00000001, 8'h00, 1'b0, 1'b1, 2};
        vecs[2] = '{8'h20, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h00, 32'hDEADBEEF, 32'h00000000, 8'h22, 1'b1, 1'b0, 1};
        vecs[4] = '{8'hE1, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 1'b1, 0};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (2) tick();
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_word_count", bus.word_count, 0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_cpu_rst", bus.cpu_rst, 1'b0);
        check("rst_byte_ready", bus.byte_ready, 1'b0);

        // First edge after reset release must honour start.
        rst_n     = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("first_start_busy", bus.busy, 1'b1);
        check("first_start_ready", bus.byte_ready, 1'b1);

        // Start with a same-cycle (bad) header byte: the byte is discarded.
        bus.start      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h20;
        tick();
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        check("start_prio_err", bus.err, 1'b0);
        check("start_prio_busy", bus.busy, 1'b1);

        // Abort after two data bytes, then a fresh one-word session.
        got_q.delete();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_start();
        check("abort_word_count", bus.word_count, 0);
        tx_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_stream();
        junk_offer();
        exp_q    = '{{5'd0, 32'h44332211}};
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_cnt  = 1;
        check_end("abort");

        foreach (vecs[v]) begin
            do_start();
            got_q.delete();
            exp_q.delete();
            tx_q.delete();
            tx_q.push_back(vecs[v].hdr);
            if (vecs[v].hdr[7:5] == 3'd0) begin
                n = int'(vecs[v].hdr[4:0]) + 1;
                for (int i = 0; i < n; i++) begin
                    wv = (i == 0) ? vecs[v].w0 : vecs[v].w1;
                    for (int k = 0; k < 4; k++) tx_q.push_back(wv[8*k +: 8]);
                end
                tx_q.push_back(vecs[v].chk);
            end
            for (int i = 0; i < vecs[v].cnt; i++) begin
                wv = (i == 0) ? vecs[v].w0 : vecs[v].w1;
                exp_q.push_back({AW'(i), wv});
            end
            exp_done = vecs[v].done;
            exp_err  = vecs[v].err;
            exp_cnt  = vecs[v].cnt;
            send_stream();
            junk_offer();
            check_end($sformatf("vec%0d", v));
        end

        // Full 32-word image.
        do_start();
        got_q.delete();
        build_random(32, 1'b1, 1'b1);
        model();
        send_stream();
        junk_offer();
        check_end("full32");

        for (int s = 0; s < 15; s++) begin
            do_start();
            got_q.delete();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 32)) : int'($urandom_range(1, 8));
            build_random(n, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
            model();
            send_stream();
            junk_offer();
            check_end($sformatf("rand%0d", s));
        end

        // Asynchronous reset in the middle of word 1.
        do_start();
        send_byte(8'h01);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        tick();
        check("mid_word_count", bus.word_count, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_cpu_rst", bus.cpu_rst, 1'b0);
        check("async_rst_word_count", bus.word_count, 0);
        check("async_rst_byte_ready", bus.byte_ready, 1'b0);
        check("async_rst_wr_data", bus.wr_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
